// File: rtl/sprite_pixel_requester.sv
// Per-pixel sprite lookup: scans object slots in priority order, issues requests to the
// sprite storage and returns the first opaque colour (or background) with a valid pulse.
module sprite_pixel_requester #(
    parameter int         NUM_SLOTS   = 4,
    parameter int         SPRITE_W    = 32,
    parameter int         SPRITE_H    = 32,
    parameter logic [7:0] TRANSPARENT = 8'hFF,
    parameter logic [7:0] BG_COLOR    = 8'h00
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            pixel_req,
    input  logic signed [31:0]                              pixelX,
    input  logic signed [31:0]                              pixelY,
    input  logic [NUM_SLOTS-1:0]                            slot_enable,
    input  logic signed [31:0]                              slot_sprite [NUM_SLOTS],
    input  logic signed [31:0]                              slot_x      [NUM_SLOTS],
    input  logic signed [31:0]                              slot_y      [NUM_SLOTS],
    output logic                                            busy,
    output logic signed [31:0]                              sprite_number,
    output logic signed [31:0]                              requested_x,
    output logic signed [31:0]                              requested_y,
    output logic signed [31:0]                              x_offset,
    output logic signed [31:0]                              y_offset,
    input  logic [7:0]                                      RGBin,
    output logic [7:0]                                      RGBout,
    output logic                                            rgb_valid,
    output logic                                            hit,
    output logic [((NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1)-1:0] hit_slot
);

    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } state_t;

    state_t state, state_next;

    logic [IDX_W-1:0]     idx;
    logic signed [31:0]   snap_px;
    logic signed [31:0]   snap_py;
    logic [NUM_SLOTS-1:0] snap_en;
    logic signed [31:0]   snap_sprite [NUM_SLOTS];
    logic signed [31:0]   snap_x      [NUM_SLOTS];
    logic signed [31:0]   snap_y      [NUM_SLOTS];

    // Tag pipeline mirrors the storage's two-cycle latency; live marks an occupied
    // scan slot, valid marks that a request was actually issued for it.
    logic             s1_live, s1_valid;
    logic [IDX_W-1:0] s1_idx;
    logic             s2_live, s2_valid;
    logic [IDX_W-1:0] s2_idx;

    logic signed [31:0] rel_x, rel_y;
    logic               accept;
    logic               candidate;
    logic               winner;
    logic               scan_done;

    assign busy = (state != IDLE);

    always_comb begin
        rel_x      = snap_px - snap_x[idx];
        rel_y      = snap_py - snap_y[idx];
        accept     = (state == IDLE) && pixel_req;
        candidate  = (state == SCAN) && snap_en[idx] &&
                     (rel_x >= 0) && (rel_x < SPRITE_W) &&
                     (rel_y >= 0) && (rel_y < SPRITE_H);
        winner     = s2_live && s2_valid && (RGBin != TRANSPARENT);
        scan_done  = s2_live && (s2_idx == LAST_IDX) && !winner;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (winner || scan_done) begin
                    state_next = IDLE;
                end else if (idx == LAST_IDX) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (winner || scan_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx           <= '0;
            snap_px       <= '0;
            snap_py       <= '0;
            snap_en       <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                snap_sprite[i] <= '0;
                snap_x[i]      <= '0;
                snap_y[i]      <= '0;
            end
            s1_live       <= 1'b0;
            s1_valid      <= 1'b0;
            s1_idx        <= '0;
            s2_live       <= 1'b0;
            s2_valid      <= 1'b0;
            s2_idx        <= '0;
            sprite_number <= '0;
            requested_x   <= '0;
            requested_y   <= '0;
            x_offset      <= '0;
            y_offset      <= '0;
            RGBout        <= 8'h00;
            rgb_valid     <= 1'b0;
            hit           <= 1'b0;
            hit_slot      <= '0;
        end else begin
            rgb_valid <= 1'b0;

            if (accept) begin
                idx         <= '0;
                snap_px     <= pixelX;
                snap_py     <= pixelY;
                snap_en     <= slot_enable;
                snap_sprite <= slot_sprite;
                snap_x      <= slot_x;
                snap_y      <= slot_y;
            end else if (state == SCAN) begin
                idx <= idx + 1'b1;
            end

            // A winner flushes the pipeline so later in-flight responses are dropped.
            if (winner) begin
                s1_live  <= 1'b0;
                s1_valid <= 1'b0;
                s2_live  <= 1'b0;
                s2_valid <= 1'b0;
            end else begin
                s1_live  <= (state == SCAN);
                s1_valid <= candidate;
                s1_idx   <= idx;
                s2_live  <= s1_live;
                s2_valid <= s1_valid;
                s2_idx   <= s1_idx;
            end

            if (candidate && !winner) begin
                sprite_number <= snap_sprite[idx];
                requested_x   <= snap_px;
                requested_y   <= snap_py;
                x_offset      <= snap_x[idx];
                y_offset      <= snap_y[idx];
            end

            if (winner) begin
                RGBout    <= RGBin;
                hit       <= 1'b1;
                hit_slot  <= s2_idx;
                rgb_valid <= 1'b1;
            end else if (scan_done) begin
                RGBout    <= BG_COLOR;
                hit       <= 1'b0;
                hit_slot  <= '0;
                rgb_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sprite_pixel_requester.sv
// Directed bench for sprite_pixel_requester with a registered storage model and a
// scoreboard of expected lookup results (colour, hit, slot, latency).
module tb_sprite_pixel_requester;

    localparam int NUM_SLOTS = 4;

    logic               clk;
    logic               reset;
    logic               pixel_req;
    logic signed [31:0] pixelX, pixelY;
    logic [NUM_SLOTS-1:0] slot_enable;
    logic signed [31:0] slot_sprite [NUM_SLOTS];
    logic signed [31:0] slot_x      [NUM_SLOTS];
    logic signed [31:0] slot_y      [NUM_SLOTS];
    logic               busy;
    logic signed [31:0] sprite_number, requested_x, requested_y, x_offset, y_offset;
    logic [7:0]         RGBin;
    logic [7:0]         RGBout;
    logic               rgb_valid;
    logic               hit;
    logic [1:0]         hit_slot;

    typedef struct {
        logic [7:0] rgb;
        logic       hit;
        int         slot;
        int         lat;
        int         accept_cyc;
    } exp_t;

    exp_t sb[$];
    logic [7:0] sprite_color [8];
    int cyc;
    int tests;
    int fails;

    sprite_pixel_requester dut (
        .clk(clk),
        .reset(reset),
        .pixel_req(pixel_req),
        .pixelX(pixelX),
        .pixelY(pixelY),
        .slot_enable(slot_enable),
        .slot_sprite(slot_sprite),
        .slot_x(slot_x),
        .slot_y(slot_y),
        .busy(busy),
        .sprite_number(sprite_number),
        .requested_x(requested_x),
        .requested_y(requested_y),
        .x_offset(x_offset),
        .y_offset(y_offset),
        .RGBin(RGBin),
        .RGBout(RGBout),
        .rgb_valid(rgb_valid),
        .hit(hit),
        .hit_slot(hit_slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered storage: colour depends only on the low bits of the sprite id.
    initial RGBin = 8'h00;
    always @(posedge clk) RGBin <= sprite_color[sprite_number[2:0]];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic exp_t modelLookup();
        exp_t e;
        int rx, ry;
        logic [31:0] spr;
        e.rgb = 8'h00; e.hit = 1'b0; e.slot = 0; e.lat = NUM_SLOTS + 2; e.accept_cyc = 0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            rx  = pixelX - slot_x[k];
            ry  = pixelY - slot_y[k];
            spr = slot_sprite[k];
            if (slot_enable[k] && rx >= 0 && rx < 32 && ry >= 0 && ry < 32 &&
                sprite_color[spr[2:0]] != 8'hFF) begin
                e.rgb = sprite_color[spr[2:0]]; e.hit = 1'b1; e.slot = k; e.lat = k + 3;
                return e;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset && rgb_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_valid", 32'(rgb_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("rgb",     32'(RGBout), 32'(e.rgb));
                checkOutput("hit",     32'(hit), 32'(e.hit));
                checkOutput("hitslot", 32'(hit_slot), 32'(e.slot));
                checkOutput("latency", 32'(cyc - e.accept_cyc), 32'(e.lat));
            end
        end
    end

    task automatic clearSlots();
        slot_enable = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_sprite[i] = 0; slot_x[i] = 0; slot_y[i] = 0;
        end
    endtask

    task automatic setSlot(input int k, input int spr, input int x, input int y);
        slot_enable[k] = 1'b1;
        slot_sprite[k] = spr;
        slot_x[k]      = x;
        slot_y[k]      = y;
    endtask

    // Called at a negedge with the DUT idle; returns #1 after the accept edge.
    task automatic applyStimulus(input logic hold);
        exp_t e;
        e = modelLookup();
        pixel_req = 1'b1;
        @(posedge clk);
        #1;
        e.accept_cyc = cyc;
        sb.push_back(e);
        if (!hold) pixel_req = 1'b0;
    endtask

    task automatic waitDone();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        checkOutput("done_timeout", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        sprite_color = '{8'h0F, 8'hFF, 8'h63, 8'h3C, 8'h81, 8'hFF, 8'h22, 8'h44};
        reset = 1'b1;
        pixel_req = 1'b0;
        pixelX = 0; pixelY = 0;
        clearSlots();
        repeat (3) @(negedge clk);
        checkOutput("rst_busy",   32'(busy), 32'd0);
        checkOutput("rst_valid",  32'(rgb_valid), 32'd0);
        checkOutput("rst_hit",    32'(hit), 32'd0);
        checkOutput("rst_slot",   32'(hit_slot), 32'd0);
        checkOutput("rst_rgb",    32'(RGBout), 32'd0);
        checkOutput("rst_sprite", sprite_number, 32'd0);
        checkOutput("rst_reqx",   requested_x, 32'd0);
        checkOutput("rst_xoff",   x_offset, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single slot hit on slot 0
        clearSlots();
        setSlot(0, 8, 100, 50);
        pixelX = 110; pixelY = 60;
        applyStimulus(1'b0);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        waitDone();
        checkOutput("t1_sprite", sprite_number, 32'd8);
        checkOutput("t1_xoff",   x_offset, 32'd100);
        checkOutput("t1_yoff",   y_offset, 32'd50);
        checkOutput("t1_reqx",   requested_x, 32'd110);

        // Slot 0 transparent, slot 2 opaque
        clearSlots();
        setSlot(0, 1, 0, 0);
        setSlot(2, 2, 10, 10);
        setSlot(3, 4, 500, 500);
        pixelX = 20; pixelY = 20;
        applyStimulus(1'b0);
        waitDone();

        // All disabled: background, request outputs untouched
        clearSlots();
        pixelX = 5; pixelY = 5;
        applyStimulus(1'b0);
        waitDone();
        checkOutput("t3_sprite", sprite_number, 32'd2);
        checkOutput("t3_xoff",   x_offset, 32'd10);

        // Bounding-box edges
        clearSlots();
        setSlot(0, 3, 100, 0);
        pixelX = 131; pixelY = 5;
        applyStimulus(1'b0);
        waitDone();
        pixelX = 132;
        applyStimulus(1'b0);
        waitDone();
        checkOutput("t4_reqx_32", requested_x, 32'd131);
        pixelX = 99;
        applyStimulus(1'b0);
        waitDone();
        checkOutput("t4_reqx_m1", requested_x, 32'd131);

        // Back-to-back with pixel_req held; inputs scrambled while busy
        for (int it = 0; it < 3; it++) begin
            if (it > 0) begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (!busy) break;
                end
                checkOutput("b2b_valid_on_idle", 32'(rgb_valid), 32'd1);
            end
            clearSlots();
            case (it)
                0: begin setSlot(1, 3, 200, 200); pixelX = 205; pixelY = 210; end
                1: begin setSlot(0, 5, 0, 0); setSlot(3, 4, 10, 0); pixelX = 20; pixelY = 5; end
                default: begin setSlot(0, 6, 40, 40); pixelX = 41; pixelY = 41; end
            endcase
            applyStimulus(it < 2);
            pixelX = pixelX + 1000;
            slot_enable = ~slot_enable;
            for (int i = 0; i < NUM_SLOTS; i++) slot_x[i] = slot_x[i] + 7;
        end
        waitDone();

        // Reset during SCAN abandons the lookup
        clearSlots();
        setSlot(2, 2, 10, 10);
        pixelX = 15; pixelY = 15;
        pixel_req = 1'b1;
        @(posedge clk);
        #1 pixel_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checkOutput("mr_busy",   32'(busy), 32'd0);
        checkOutput("mr_valid",  32'(rgb_valid), 32'd0);
        checkOutput("mr_hit",    32'(hit), 32'd0);
        checkOutput("mr_slot",   32'(hit_slot), 32'd0);
        checkOutput("mr_rgb",    32'(RGBout), 32'd0);
        checkOutput("mr_sprite", sprite_number, 32'd0);
        checkOutput("mr_reqx",   requested_x, 32'd0);
        checkOutput("mr_xoff",   x_offset, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("mr_idle_after", 32'(busy), 32'd0);
        applyStimulus(1'b0);
        waitDone();
        checkOutput("mr_sprite_after", sprite_number, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sprite_pixel_requester.md
# sprite_pixel_requester

Requester side of the sprite storage lookup: for one screen pixel it walks a fixed list of object slots in priority order and drives sprite_number/requested_x/requested_y/x_offset/y_offset into a sprite storage block. It consumes the storage's registered 8-bit colour and returns the first opaque colour, or a background colour, with a one-cycle valid pulse. It sits between the per-object position logic and the VGA pixel mux, running on the system clock, which is faster than the pixel rate.

## Interface
- NUM_SLOTS, 4: number of object slots; slot 0 has the highest priority.
- SPRITE_W, 32: bounding-box width in pixels.
- SPRITE_H, 32: bounding-box height in pixels.
- TRANSPARENT, 8'hFF: storage colour treated as "no pixel".
- BG_COLOR, 8'h00: colour returned when no slot hits.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- pixel_req  in  1  start a lookup; sampled only while idle.
- pixelX, pixelY  in  int  screen coordinate, latched on accept.
- slot_enable  in  NUM_SLOTS  per-slot enable, latched on accept.
- slot_sprite, slot_x, slot_y  in  NUM_SLOTS x int  sprite id and top-left position per slot, latched on accept.
- busy  out  1  high from the accept edge until the result edge.
- sprite_number, requested_x, requested_y, x_offset, y_offset  out  int  registered request to the storage.
- RGBin  in  8  storage RGBout.
- RGBout  out  8  resolved colour.
- rgb_valid  out  1  one-cycle pulse; RGBout is valid while it is high.
- hit  out  1  high with rgb_valid if an opaque slot won.
- hit_slot  out  $clog2(NUM_SLOTS)  index of the winning slot; 0 when hit is low.

## Operation
- States:
  - IDLE: on pixel_req, snapshot all inputs, set idx=0, go to SCAN.
  - SCAN: one slot per cycle, idx 0..NUM_SLOTS-1; after the last slot go to DRAIN.
  - DRAIN: wait for in-flight responses, then return to IDLE.
- Candidate test:
  - rel_x = pixelX - slot_x[idx] and rel_y = pixelY - slot_y[idx], signed 32-bit.
  - A slot is a candidate iff it is enabled, 0 <= rel_x < SPRITE_W and 0 <= rel_y < SPRITE_H.
- Issuing a request:
  - A candidate registers sprite_number=slot_sprite, requested_x=pixelX, requested_y=pixelY, x_offset=slot_x, y_offset=slot_y.
  - It also pushes {valid, idx} into a 2-stage tag pipeline.
  - A non-candidate pushes an invalid tag, and the request outputs hold their values.
- Response check: when a valid tag leaves stage 2, RGBin is its response.
  - RGBin != TRANSPARENT: winner. Set RGBout=RGBin, hit=1, hit_slot=tag idx, pulse rgb_valid, flush tags, return to IDLE. Later in-flight responses are discarded.
  - Otherwise: continue.
- No winner: when the slot after NUM_SLOTS-1 has cleared stage 2, set RGBout=BG_COLOR, hit=0, hit_slot=0, and pulse rgb_valid.
- Priority is strictly by index, because issue and check order match.
- pixel_req while busy is ignored; there is no queue.
- Request outputs hold their last value between lookups.

## Timing
- Reset values:
  - State IDLE; busy=0, rgb_valid=0, hit=0, hit_slot=0.
  - RGBout=8'h00.
  - All request outputs 0; tags invalid.
- Issue-to-response path:
  - Accept at edge E0.
  - Slot k is evaluated and issued at edge E(k+1).
  - The storage samples it at E(k+2), and the response is checked at E(k+3).
- Result latency:
  - Hit on slot k: result registered at E(k+3); rgb_valid high in the following cycle.
  - No hit (including no candidates): result registered at E(NUM_SLOTS+2), a fixed latency.
- busy falls on the same edge that sets rgb_valid. A pixel_req in the rgb_valid cycle is accepted.
- Reset asserted mid-lookup: everything returns to reset values immediately, with no rgb_valid.
- A lookup that is only partly issued is abandoned.

## Test plan
- Slot 0 enabled at (100,50), pixel (110,60), storage returns 8'h0F -> rgb_valid 3 cycles after accept, RGBout=8'h0F, hit=1, hit_slot=0, sprite_number=slot_sprite[0], x_offset=100.
- Slots 0 and 2 are candidates, slot 0 returns 8'hFF and slot 2 returns 8'h63 -> RGBout=8'h63, hit_slot=2, rgb_valid 5 cycles after accept.
- All slots disabled -> RGBout=8'h00, hit=0, rgb_valid exactly NUM_SLOTS+2 cycles after accept; no request outputs change.
- Edge boxes: pixel at rel_x=31 hits; rel_x=32 and rel_x=-1 miss (no request issued).
- pixel_req held high continuously -> back-to-back lookups; new accept in each rgb_valid cycle; inputs changed while busy have no effect.
- Reset pulsed during SCAN -> all outputs at reset values, no rgb_valid; the next pixel_req completes normally.
